morph_window_3x3: RTL and testbench

- Downstream consumer of the programmable-delay line-buffer FIFO chain in the image-processing path.
- Takes the current pixel plus the 1-line-delayed and 2-line-delayed taps produced by two cascaded line FIFOs (FIFO size = image width).
- Assembles a 3x3 window and applies a per-bit binary morphological operation (pass, erode, dilate, majority) to N-bit class masks.
- Emits a valid-qualified pixel stream with line and frame markers.

---
 rtl/morph_window_3x3.sv | 158 +++++++++++++++
 tb/tb_morph_window_3x3.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_window_3x3.sv
// 3x3 binary morphology window for N-bit class masks.
// Consumes the current pixel plus the 1- and 2-line-delayed taps from the
// line FIFO chain, builds a sliding 3x3 window and applies pass / erode /
// dilate / majority independently to each bit plane. The output stream is
// valid-qualified and carries line and frame markers for the inner
// (w-2) x (h-2) region.
module morph_window_3x3 #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N-1:0]     row_cur,
  input  logic [N-1:0]     row_d1,
  input  logic [N-1:0]     row_d2,
  input  logic [CNT_W-1:0] img_width,
  input  logic [CNT_W-1:0] img_height,
  input  logic [1:0]       mode,
  output logic [N-1:0]     data_out,
  output logic             out_valid,
  output logic             out_line_end,
  output logic             out_frame_end
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_MAJ    = 2'b11
  } mode_e;

  // Frame geometry and operator, frozen for the duration of a frame.
  logic [CNT_W-1:0] w_l;
  logic [CNT_W-1:0] h_l;
  mode_e            m_l;

  // Column / row position of the pixel presented on the current strobe.
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;

  // win[row][col]: row 0 = line y-2, row 2 = line y;
  // col 0 = column x-2, col 2 = newest column x.
  logic [N-1:0] win [3][3];

  logic         win_valid;
  logic         line_last;
  logic         frame_last;
  logic [N-1:0] filt;

  logic x_last;
  logic y_last;
  logic in_core;

  assign x_last  = (x == w_l - CNT_W'(1));
  assign y_last  = (y == h_l - CNT_W'(1));
  // Both earlier columns and both earlier lines belong to this frame/line.
  assign in_core = (x >= CNT_W'(2)) && (y >= CNT_W'(2));

  // Per-bit operator on the nine window samples; bit 4 is the centre.
  function automatic logic op_bit(input logic [8:0] v, input mode_e m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + 4'(v[i]);
    case (m)
      MODE_PASS:   return v[4];
      MODE_ERODE:  return &v;
      MODE_DILATE: return |v;
      default:     return (cnt >= 4'd5);
    endcase
  endfunction

  // Position counters and configuration shadow reload at frame boundary.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      x   <= '0;
      y   <= '0;
      w_l <= img_width;
      h_l <= img_height;
      m_l <= mode_e'(mode);
    end else if (enable) begin
      if (x_last) begin
        x <= '0;
        if (y_last) begin
          y   <= '0;
          w_l <= img_width;
          h_l <= img_height;
          m_l <= mode_e'(mode);
        end else begin
          y <= y + CNT_W'(1);
        end
      end else begin
        x <= x + CNT_W'(1);
      end
    end
  end

  // Window shift: oldest column drops out, newest column loads the taps.
  always_ff @(posedge clk) begin
    // NOTE: the window is nine ordinary flops, not a RAM, so clearing it
    // on reset costs nothing and keeps data_out deterministic.
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else if (enable) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row_d2;
      win[1][2] <= row_d1;
      win[2][2] <= row_cur;
    end
  end

  // Window qualification, registered alongside the window shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_valid  <= 1'b0;
      line_last  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      win_valid  <= enable && in_core;
      line_last  <= enable && in_core && x_last;
      frame_last <= enable && in_core && x_last && y_last;
    end
  end

  // Morphological operator applied to every bit plane of the window.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred.
    filt = '0;
    for (int b = 0; b < N; b++) begin
      filt[b] = op_bit({win[2][2][b], win[2][1][b], win[2][0][b],
                        win[1][2][b], win[1][1][b], win[1][0][b],
                        win[0][2][b], win[0][1][b], win[0][0][b]}, m_l);
    end
  end

  // Output register: free-running, data holds between valid windows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out      <= '0;
      out_valid     <= 1'b0;
      out_line_end  <= 1'b0;
      out_frame_end <= 1'b0;
    end else begin
      out_valid     <= win_valid;
      out_line_end  <= line_last;
      out_frame_end <= frame_last;
      if (win_valid) data_out <= filt;
    end
  end

endmodule

// File: tb/tb_morph_window_3x3.sv
// Directed bench for morph_window_3x3: pass/erode/dilate/majority frames,
// enable gaps, mid-frame configuration change, mid-frame reset and
// degenerate image sizes. Inputs are driven on the falling edge and outputs
// are collected on the falling edge.
module tb_morph_window_3x3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  row_cur, row_d1, row_d2;
  logic [15:0] img_width, img_height;
  logic [1:0]  mode;
  logic [2:0]  data_out;
  logic        out_valid, out_line_end, out_frame_end;

  morph_window_3x3 #(.N(3), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .row_cur       (row_cur),
    .row_d1        (row_d1),
    .row_d2        (row_d2),
    .img_width     (img_width),
    .img_height    (img_height),
    .mode          (mode),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .out_line_end  (out_line_end),
    .out_frame_end (out_frame_end)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_bad = 0;

  logic [2:0] img [16][16];
  logic [2:0] q_data [$];
  logic       q_le [$];
  logic       q_fe [$];
  logic       en_q1 = 1'b0, en_q2 = 1'b0;

  // Enable history: en_q2 is the enable seen one edge before the latest.
  always @(posedge clk) begin
    en_q2 <= en_q1;
    en_q1 <= enable;
  end

  // Output collector; every strobe must follow an accepting edge by 1 clk.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_data.push_back(data_out);
      q_le.push_back(out_line_end);
      q_fe.push_back(out_frame_end);
      if (en_q2 !== 1'b1) lat_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_le.delete();
    q_fe.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic do_reset(input int w, input int h, input logic [1:0] m);
    @(negedge clk);
    img_width  = 16'(w);
    img_height = 16'(h);
    mode       = m;
    enable     = 1'b0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fill_mod(input int w);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) img[yy][xx] = 3'((yy * w + xx) % 8);
  endtask

  task automatic fill_const(input logic [2:0] v);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) img[yy][xx] = v;
  endtask

  task automatic send_px(input int xx, input int yy, input int gap_pct);
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      @(negedge clk);
      enable = 1'b0;
    end
    @(negedge clk);
    enable  = 1'b1;
    row_cur = img[yy][xx];
    row_d1  = 3'b000;
    row_d2  = 3'b000;
    if (yy >= 1) row_d1 = img[yy-1][xx];
    if (yy >= 2) row_d2 = img[yy-2][xx];
  endtask

  task automatic feed_frame(input int w, input int h, input int gap_pct);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) send_px(xx, yy, gap_pct);
  endtask

  function automatic logic [31:0] le_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < q_le.size() && i < 32; i++) m[i] = q_le[i];
    return m;
  endfunction

  function automatic logic [31:0] fe_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < q_fe.size() && i < 32; i++) m[i] = q_fe[i];
    return m;
  endfunction

  task automatic check_seq(input string tag, input int n, input logic [2:0] e [8]);
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [2:0] got;
      got = (i < q_data.size()) ? q_data[i] : 3'bxxx;
      check($sformatf("%s_data%0d", tag, i), 32'(got), 32'(e[i]));
    end
  endtask

  // Hand-computed centre values (pixel = (y*W+x) mod 8).
  logic [2:0] exp_w5 [8] = '{3'd6, 3'd7, 3'd0, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
  logic [2:0] exp_w6 [8] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    int nz;
    reset_n = 1'b0; enable = 1'b0;
    row_cur = '0; row_d1 = '0; row_d2 = '0;
    img_width = 16'd5; img_height = 16'd4; mode = 2'b00;

    // Reset state
    do_reset(5, 4, 2'b00);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_line_end", 32'(out_line_end), 0);
    check("rst_frame_end", 32'(out_frame_end), 0);

    // Pass mode, gap-free 5x4
    fill_mod(5);
    clear_q();
    feed_frame(5, 4, 0);
    idle(4);
    check_seq("pass", 6, exp_w5);
    check("pass_line_end", le_mask(), 32'h24);
    check("pass_frame_end", fe_mask(), 32'h20);

    // Same stream with ~50% enable gaps
    clear_q();
    lat_bad = 0;
    feed_frame(5, 4, 50);
    idle(4);
    check_seq("gap", 6, exp_w5);
    check("gap_line_end", le_mask(), 32'h24);
    check("gap_frame_end", fe_mask(), 32'h20);
    check("gap_latency", 32'(lat_bad), 0);

    // Reset at pixel (3,2) mid-frame
    clear_q();
    for (int p = 0; p < 13; p++) send_px(p % 5, p / 5, 0);
    @(negedge clk);
    check("mrst_pre_data", 32'(data_out), 5);
    reset_n = 1'b0;
    enable  = 1'b1;
    row_cur = img[2][3]; row_d1 = img[1][3]; row_d2 = img[0][3];
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    check("mrst_data", 32'(data_out), 0);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_no_output", 32'(q_data.size()), 0);
    clear_q();
    feed_frame(5, 4, 0);
    idle(4);
    check_seq("mrst_restart", 6, exp_w5);

    // Width changed 5 -> 6 mid-frame; takes effect on the next frame
    clear_q();
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 5; xx++) begin
        if (yy == 2 && xx == 0) img_width = 16'd6;
        send_px(xx, yy, 0);
      end
    idle(4);
    check_seq("wchg_old", 6, exp_w5);
    fill_mod(6);
    clear_q();
    feed_frame(6, 4, 0);
    idle(4);
    check_seq("wchg_new", 8, exp_w6);
    check("wchg_line_end", le_mask(), 32'h88);
    check("wchg_frame_end", fe_mask(), 32'h80);

    // Erode: all ones with one hole at (2,2)
    do_reset(5, 5, 2'b01);
    fill_const(3'b111);
    img[2][2] = 3'b000;
    clear_q();
    feed_frame(5, 5, 0);
    idle(4);
    nz = 0;
    foreach (q_data[i]) if (q_data[i] !== 3'b000) nz++;
    check("erode_count", q_data.size(), 9);
    check("erode_not_zero", 32'(nz), 0);
    check("erode_frame_end", fe_mask(), 32'h100);

    // Dilate: all zeros with one 7 at (2,2)
    do_reset(5, 5, 2'b10);
    fill_const(3'b000);
    img[2][2] = 3'b111;
    clear_q();
    feed_frame(5, 5, 0);
    idle(4);
    nz = 0;
    foreach (q_data[i]) if (q_data[i] !== 3'b111) nz++;
    check("dilate_count", q_data.size(), 9);
    check("dilate_not_seven", 32'(nz), 0);

    // Majority: bit0 set in 5 of 9, bit1 and bit2 in 4 of 9
    do_reset(3, 3, 2'b11);
    img[0][0] = 3'd5; img[0][1] = 3'd5; img[0][2] = 3'd5;
    img[1][0] = 3'd5; img[1][1] = 3'd3; img[1][2] = 3'd2;
    img[2][0] = 3'd2; img[2][1] = 3'd2; img[2][2] = 3'd0;
    clear_q();
    feed_frame(3, 3, 0);
    idle(4);
    check("maj_count", q_data.size(), 1);
    check("maj_data", (q_data.size() > 0) ? 32'(q_data[0]) : 32'hx, 32'h1);

    // W=2, H=10: never valid; after two 20-enable frames, switch ports so
    // the third frame end reloads 5x4, proving the wrap point.
    do_reset(2, 10, 2'b00);
    fill_mod(2);
    clear_q();
    feed_frame(2, 10, 0);
    feed_frame(2, 10, 0);
    idle(1);
    img_width  = 16'd5;
    img_height = 16'd4;
    feed_frame(2, 10, 0);
    idle(4);
    check("narrow_no_valid", 32'(q_data.size()), 0);
    fill_mod(5);
    clear_q();
    feed_frame(5, 4, 0);
    idle(4);
    check_seq("narrow_wrap", 6, exp_w5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
